// File: rtl/rgb_fade_pkg.sv
// rtl/rgb_fade_pkg.sv - shared types and hue-phase ramp table for the RGB fader
package rgb_fade_pkg;

  typedef enum logic [2:0] {PH_0, PH_1, PH_2, PH_3, PH_4, PH_5} phase_t;

  typedef enum logic [1:0] {HOLD_LO, HOLD_HI, RISE, FALL} ramp_t;

  // Channel index: 0 = red, 1 = green, 2 = blue.
  function automatic ramp_t phase_ramp(phase_t ph, logic [1:0] ch);
    ramp_t r;
    r = HOLD_LO;
    case (ph)
      PH_0: r = (ch == 2'd0) ? HOLD_HI : (ch == 2'd1) ? RISE    : HOLD_LO;
      PH_1: r = (ch == 2'd0) ? FALL    : (ch == 2'd1) ? HOLD_HI : HOLD_LO;
      PH_2: r = (ch == 2'd0) ? HOLD_LO : (ch == 2'd1) ? HOLD_HI : RISE;
      PH_3: r = (ch == 2'd0) ? HOLD_LO : (ch == 2'd1) ? FALL    : HOLD_HI;
      PH_4: r = (ch == 2'd0) ? RISE    : (ch == 2'd1) ? HOLD_LO : HOLD_HI;
      PH_5: r = (ch == 2'd0) ? HOLD_HI : (ch == 2'd1) ? HOLD_LO : FALL;
      default: r = HOLD_LO;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rgb_fade_if.sv
// rtl/rgb_fade_if.sv - active-low RGB LED drive bundle
interface rgb_fade_if;
  logic RGB_R;
  logic RGB_G;
  logic RGB_B;

  modport master (output RGB_R, output RGB_G, output RGB_B);
  modport slave  (input  RGB_R, input  RGB_G, input  RGB_B);
endinterface

// File: rtl/rgb_fade_pwm_channel.sv
// rtl/rgb_fade_pwm_channel.sv - one registered active-low PWM comparator
module pwm_channel #(
  parameter int PWM_INTERVAL = 1200,
  localparam int DW = $clog2(PWM_INTERVAL + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] cnt,
  input  logic [DW-1:0] duty,
  output logic          pin_n
);

  always_ff @(posedge clk) begin
    if (rst) pin_n <= 1'b1;
    else     pin_n <= ~(cnt < duty);
  end

endmodule

// File: rtl/rgb_fade_top.sv
// rtl/rgb_fade_top.sv - HSV hue-wheel fader: PWM counter, step timer, phase FSM, duties
module rgb_fade_top
  import rgb_fade_pkg::*;
#(
  parameter int PWM_INTERVAL     = 1200,
  parameter int INC_DEC_INTERVAL = 10000,
  parameter int INC_DEC_MAX      = 200
) (
  input  logic       clk,
  input  logic       rst,
  rgb_fade_if.master led
);

  localparam int INC_DEC_VAL = PWM_INTERVAL / INC_DEC_MAX;
  localparam int DW = $clog2(PWM_INTERVAL + 1);
  localparam int SW = $clog2(INC_DEC_INTERVAL);
  localparam int IW = $clog2(INC_DEC_MAX);

  localparam logic [DW-1:0] FULL      = DW'(PWM_INTERVAL);
  localparam logic [DW-1:0] STEP      = DW'(INC_DEC_VAL);
  localparam logic [DW-1:0] CNT_LAST  = DW'(PWM_INTERVAL - 1);
  localparam logic [SW-1:0] TICK_LAST = SW'(INC_DEC_INTERVAL - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(INC_DEC_MAX - 1);

  logic [DW-1:0] pwm_cnt;
  logic [SW-1:0] step_cnt;
  logic [IW-1:0] step_idx;
  logic [DW-1:0] duty [3];
  phase_t        phase, phase_nxt;
  ramp_t         ramp [3];
  logic          tick, phase_end;

  assign tick      = (step_cnt == TICK_LAST);
  assign phase_end = tick && (step_idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt  <= '0;
      step_cnt <= '0;
      step_idx <= '0;
    end else begin
      pwm_cnt  <= (pwm_cnt == CNT_LAST) ? '0 : pwm_cnt + DW'(1);
      step_cnt <= tick ? '0 : step_cnt + SW'(1);
      if (tick) step_idx <= phase_end ? '0 : step_idx + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) phase <= PH_0;
    else     phase <= phase_nxt;
  end

  always_comb begin
    phase_nxt = phase;
    if (phase_end) begin
      case (phase)
        PH_0:    phase_nxt = PH_1;
        PH_1:    phase_nxt = PH_2;
        PH_2:    phase_nxt = PH_3;
        PH_3:    phase_nxt = PH_4;
        PH_4:    phase_nxt = PH_5;
        default: phase_nxt = PH_0;
      endcase
    end
  end

  always_comb begin
    for (int c = 0; c < 3; c++) ramp[c] = phase_ramp(phase, 2'(c));
  end

  // The last step of a phase lands exactly on the endpoint so rounding in
  // INC_DEC_VAL can never accumulate across phases.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (rst) begin
        duty[c] <= (c == 0) ? FULL : '0;
      end else if (tick) begin
        case (ramp[c])
          RISE:    duty[c] <= (phase_end || duty[c] > FULL - STEP) ? FULL : duty[c] + STEP;
          FALL:    duty[c] <= (phase_end || duty[c] < STEP) ? '0 : duty[c] - STEP;
          default: duty[c] <= duty[c];
        endcase
      end
    end
  end

  pwm_channel #(.PWM_INTERVAL(PWM_INTERVAL)) u_pwm_r (
    .clk(clk), .rst(rst), .cnt(pwm_cnt), .duty(duty[0]), .pin_n(led.RGB_R));
  pwm_channel #(.PWM_INTERVAL(PWM_INTERVAL)) u_pwm_g (
    .clk(clk), .rst(rst), .cnt(pwm_cnt), .duty(duty[1]), .pin_n(led.RGB_G));
  pwm_channel #(.PWM_INTERVAL(PWM_INTERVAL)) u_pwm_b (
    .clk(clk), .rst(rst), .cnt(pwm_cnt), .duty(duty[2]), .pin_n(led.RGB_B));

endmodule

// File: tb/tb_rgb_fade_top.sv
// tb/tb_rgb_fade_top.sv - self-checking bench for rgb_fade_top against a closed-form hue-wheel model
module tb_rgb_fade_top;

  localparam int P  = 12;
  localparam int TI = 10;
  localparam int TM = 4;
  localparam int TV = P / TM;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n = 0;
  int   g_low = 0;

  // Ramp codes per phase, channel order R,G,B: 0 lo, 1 hi, 2 rise, 3 fall.
  int wheel [6][3] = '{'{1, 2, 0}, '{3, 1, 0}, '{0, 1, 2},
                       '{0, 3, 1}, '{2, 0, 1}, '{1, 0, 3}};

  rgb_fade_if led ();

  rgb_fade_top #(.PWM_INTERVAL(P), .INC_DEC_INTERVAL(TI), .INC_DEC_MAX(TM)) dut (
    .clk(clk), .rst(rst), .led(led));

  always #5 clk = ~clk;

  // Duty of a channel after m clock edges since reset release.
  function automatic int duty_at(int ch, int m);
    int t, ph, idx, code;
    t    = m / TI;
    ph   = (t / TM) % 6;
    idx  = t % TM;
    code = wheel[ph][ch];
    case (code)
      0:       return 0;
      1:       return P;
      2:       return (TV * idx > P) ? P : TV * idx;
      default: return (P - TV * idx < 0) ? 0 : P - TV * idx;
    endcase
  endfunction

  // Pin is the registered, inverted "counter below duty" of the previous cycle.
  function automatic logic pin_at(int ch, int m);
    if (m < 1) return 1'b1;
    return !(((m - 1) % P) < duty_at(ch, m - 1));
  endfunction

  task automatic check(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, n, obs, exp);
    end
  endtask

  task automatic run(int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      n++;
      check("pin_r", led.RGB_R, pin_at(0, n));
      check("pin_g", led.RGB_G, pin_at(1, n));
      check("pin_b", led.RGB_B, pin_at(2, n));
      if (n >= 11 && n <= 22 && led.RGB_G === 1'b0) g_low++;
    end
  endtask

  task automatic do_reset(int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("rst_r", led.RGB_R, 1'b1);
      check("rst_g", led.RGB_G, 1'b1);
      check("rst_b", led.RGB_B, 1'b1);
    end
    rst = 1'b0;
    n = 0;
  endtask

  initial begin
    do_reset(5);
    run(10);
    run(30);
    checks++;
    assert (g_low === TV) else begin
      errors++;
      $error("FAIL g_low_per_period observed=%0d expected=%0d", g_low, TV);
    end
    run(57);
    do_reset(3);
    run(2 * 6 * TM * TI + 20);
    for (int k = 0; k < 6; k++) begin
      do_reset($urandom_range(1, 4));
      run($urandom_range(15, 300));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
